sdr_port_arbiter: RTL and testbench

Four-port round-robin arbiter and burst sequencer for the SDRAM controller. It sits between the host-side FIFOs and the SDRAM command/data path. It grants one requester at a time (ports 0–1 are writes, ports 2–3 are reads), presents the burst command, and counts data beats. During write bursts it drives the byte-mask and data-select into the SDRAM data path. It holds off new grants while a refresh is pending.

---
 rtl/sdr_port_arbiter.sv | 117 +++++++++++
 tb/tb_sdr_port_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdr_port_arbiter.sv
// sdr_port_arbiter: four-port round-robin arbiter and burst sequencer for the SDRAM controller
module sdr_port_arbiter #(
    parameter int DSIZE = 32,
    parameter int ASIZE = 23,
    parameter int LEN_W = 9
) (
    input  logic                   CLK,
    input  logic                   RESET_N,
    input  logic [3:0]             REQ,
    input  logic [4*ASIZE-1:0]     ADDR,
    input  logic [4*LEN_W-1:0]     LEN,
    input  logic                   REF_PEND,
    input  logic                   CMD_ACK,
    input  logic                   BEAT,
    output logic                   CMD_VALID,
    output logic                   CMD_WRITE,
    output logic [ASIZE-1:0]       CMD_ADDR,
    output logic [LEN_W-1:0]       CMD_LEN,
    output logic [3:0]             GRANT,
    output logic [3:0]             DONE,
    output logic [DSIZE/8-1:0]     DM_OUT,
    output logic                   WR_SEL
);

    typedef enum logic [1:0] {IDLE, ISSUE, XFER, FIN} state_t;

    state_t           state, state_next;
    logic [1:0]       ptr, gidx, winner, idx;
    logic             found;
    logic [3:0]       elig;
    logic [LEN_W-1:0] cnt;

    // a port is eligible only with a request and a nonzero length
    always_comb begin
        elig = '0;
        for (int i = 0; i < 4; i++)
            elig[i] = REQ[i] && (LEN[i*LEN_W +: LEN_W] != '0);
    end

    // round-robin search from ptr; descending scan so the nearest offset wins
    always_comb begin
        winner = ptr;
        found  = 1'b0;
        idx    = ptr;
        for (int k = 3; k >= 0; k--) begin
            idx = ptr + 2'(k);
            if (elig[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    // next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:  state_next = (!REF_PEND && found) ? ISSUE : IDLE;
            ISSUE: state_next = CMD_ACK ? XFER : ISSUE;
            XFER:  state_next = (BEAT && cnt == LEN_W'(1)) ? FIN : XFER;
            FIN:   state_next = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) state <= IDLE;
        else          state <= state_next;
    end

    // registered command, grant, beat counter, mask and completion outputs
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            ptr       <= '0;
            gidx      <= '0;
            cnt       <= '0;
            GRANT     <= '0;
            DONE      <= '0;
            CMD_VALID <= 1'b0;
            CMD_WRITE <= 1'b0;
            CMD_ADDR  <= '0;
            CMD_LEN   <= '0;
            WR_SEL    <= 1'b0;
            DM_OUT    <= '1;
        end else begin
            DONE <= '0;
            case (state)
                IDLE: if (state_next == ISSUE) begin
                    gidx      <= winner;
                    GRANT     <= 4'b0001 << winner;
                    CMD_VALID <= 1'b1;
                    CMD_WRITE <= !winner[1];
                    CMD_ADDR  <= ADDR[winner*ASIZE +: ASIZE];
                    CMD_LEN   <= LEN[winner*LEN_W +: LEN_W];
                    cnt       <= LEN[winner*LEN_W +: LEN_W];
                    WR_SEL    <= !winner[1] && winner[0];
                end
                ISSUE: if (CMD_ACK) begin
                    CMD_VALID <= 1'b0;
                    if (CMD_WRITE) DM_OUT <= '0;
                end
                XFER: if (BEAT) begin
                    cnt <= cnt - LEN_W'(1);
                    if (cnt == LEN_W'(1)) begin
                        DONE   <= GRANT;
                        DM_OUT <= '1;
                    end
                end
                FIN: begin
                    GRANT <= '0;
                    ptr   <= gidx + 2'd1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdr_port_arbiter.sv
// tb_sdr_port_arbiter: directed scenario bench for the SDRAM port arbiter
module tb_sdr_port_arbiter;

    localparam int DSIZE = 32;
    localparam int ASIZE = 23;
    localparam int LEN_W = 9;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [3:0]           req = '0;
    logic [4*ASIZE-1:0]   addr = '0;
    logic [4*LEN_W-1:0]   len = '0;
    logic                 ref_pend = 1'b0;
    logic                 cmd_ack = 1'b0;
    logic                 beat = 1'b0;
    logic                 cmd_valid, cmd_write, wr_sel;
    logic [ASIZE-1:0]     cmd_addr;
    logic [LEN_W-1:0]     cmd_len;
    logic [3:0]           grant, done;
    logic [DSIZE/8-1:0]   dm_out;

    int tests = 0;
    int fails = 0;

    sdr_port_arbiter #(.DSIZE(DSIZE), .ASIZE(ASIZE), .LEN_W(LEN_W)) dut (
        .CLK(clk), .RESET_N(rst_n), .REQ(req), .ADDR(addr), .LEN(len),
        .REF_PEND(ref_pend), .CMD_ACK(cmd_ack), .BEAT(beat),
        .CMD_VALID(cmd_valid), .CMD_WRITE(cmd_write), .CMD_ADDR(cmd_addr),
        .CMD_LEN(cmd_len), .GRANT(grant), .DONE(done), .DM_OUT(dm_out), .WR_SEL(wr_sel)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic do_reset;
        rst_n = 1'b0; req = '0; ref_pend = 1'b0; cmd_ack = 1'b0; beat = 1'b0;
        tick; tick;
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        tick;
        tests++;
        if ({cmd_valid, cmd_write, cmd_addr, cmd_len, grant, done, dm_out, wr_sel} !==
            {1'b0, 1'b0, 23'h0, 9'h0, 4'h0, 4'h0, 4'hF, 1'b0}) begin
            fails++;
            $display("FAIL reset_values got %h want %h",
                {cmd_valid, cmd_write, cmd_addr, cmd_len, grant, done, dm_out, wr_sel},
                {1'b0, 1'b0, 23'h0, 9'h0, 4'h0, 4'h0, 4'hF, 1'b0});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_single_write;
        req = 4'b0001; addr[0 +: ASIZE] = 23'h000100; len[0 +: LEN_W] = 9'd8; cmd_ack = 1'b1; beat = 1'b0;
        tick;
        tests++;
        if ({cmd_valid, cmd_write, cmd_addr, cmd_len, grant, dm_out, wr_sel} !==
            {1'b1, 1'b1, 23'h000100, 9'd8, 4'b0001, 4'hF, 1'b0}) begin
            fails++;
            $display("FAIL write_issue got %h want %h",
                {cmd_valid, cmd_write, cmd_addr, cmd_len, grant, dm_out, wr_sel},
                {1'b1, 1'b1, 23'h000100, 9'd8, 4'b0001, 4'hF, 1'b0});
        end
        for (int i = 0; i < 8; i++) begin
            tick;
            tests++;
            if ({cmd_valid, dm_out, done} !== {1'b0, 4'h0, 4'h0}) begin
                fails++;
                $display("FAIL write_xfer beat %0d got %h want %h", i, {cmd_valid, dm_out, done}, {1'b0, 4'h0, 4'h0});
            end
            beat = 1'b1;
        end
        tick;
        beat = 1'b0; req = '0; cmd_ack = 1'b0;
        tests++;
        if ({done, dm_out, grant} !== {4'b0001, 4'hF, 4'b0001}) begin
            fails++;
            $display("FAIL write_done got %h want %h", {done, dm_out, grant}, {4'b0001, 4'hF, 4'b0001});
        end
        tick;
        tests++;
        if ({done, grant, cmd_valid} !== {4'h0, 4'h0, 1'b0}) begin
            fails++;
            $display("FAIL write_idle got %h want %h", {done, grant, cmd_valid}, {4'h0, 4'h0, 1'b0});
        end
    endtask

    task automatic test_fairness;
        logic [3:0] exp_g;
        logic       exp_w, bad;
        int         n;
        do_reset;
        req = 4'hF;
        for (int i = 0; i < 4; i++) len[i*LEN_W +: LEN_W] = 9'd2;
        cmd_ack = 1'b1; beat = 1'b1;
        for (int g = 0; g < 5; g++) begin
            exp_g = 4'(1 << (g % 4));
            exp_w = (g % 4) < 2;
            n = 0;
            tick;
            while (!cmd_valid && n < 20) begin tick; n++; end
            tests++;
            if ({cmd_valid, grant, cmd_write} !== {1'b1, exp_g, exp_w}) begin
                fails++;
                $display("FAIL fair_grant %0d got %h want %h", g, {cmd_valid, grant, cmd_write}, {1'b1, exp_g, exp_w});
            end
            tests++;
            if (n !== (g == 0 ? 0 : 1)) begin
                fails++;
                $display("FAIL fair_gap %0d got %0d want %0d", g, n, (g == 0 ? 0 : 1));
            end
            bad = 1'b0; n = 0;
            while (done == 4'h0 && n < 20) begin
                if (dm_out !== 4'hF) bad = 1'b1;
                tick; n++;
            end
            tests++;
            if (done !== exp_g) begin
                fails++;
                $display("FAIL fair_done %0d got %h want %h", g, done, exp_g);
            end
            if (!exp_w) begin
                tests++;
                if (bad !== 1'b0) begin
                    fails++;
                    $display("FAIL fair_read_dm %0d got dm_out low want all ones", g);
                end
            end
        end
        req = '0; cmd_ack = 1'b0; beat = 1'b0;
        tick; tick;
    endtask

    task automatic test_refresh;
        logic bad;
        do_reset;
        ref_pend = 1'b1; req = 4'b0100; len[2*LEN_W +: LEN_W] = 9'd1; cmd_ack = 1'b0; beat = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick;
            if (cmd_valid !== 1'b0 || grant !== 4'h0) bad = 1'b1;
        end
        tests++;
        if (bad !== 1'b0) begin
            fails++;
            $display("FAIL ref_block got grant during refresh want none");
        end
        ref_pend = 1'b0;
        tick;
        tests++;
        if ({cmd_valid, cmd_write, grant} !== {1'b1, 1'b0, 4'b0100}) begin
            fails++;
            $display("FAIL ref_release got %h want %h", {cmd_valid, cmd_write, grant}, {1'b1, 1'b0, 4'b0100});
        end
        cmd_ack = 1'b1;
        tick;
        cmd_ack = 1'b0; beat = 1'b1;
        tick;
        beat = 1'b0; req = '0;
        tests++;
        if (done !== 4'b0100) begin
            fails++;
            $display("FAIL ref_done got %h want %h", done, 4'b0100);
        end
        tick;
    endtask

    task automatic test_zero_len;
        logic bad;
        int   n;
        do_reset;
        req = 4'b0011; len[0 +: LEN_W] = 9'd0; len[LEN_W +: LEN_W] = 9'd4; cmd_ack = 1'b1; beat = 1'b1;
        n = 0;
        tick;
        while (!cmd_valid && n < 20) begin tick; n++; end
        tests++;
        if ({cmd_valid, grant} !== {1'b1, 4'b0010}) begin
            fails++;
            $display("FAIL zero_grant got %h want %h", {cmd_valid, grant}, {1'b1, 4'b0010});
        end
        n = 0;
        while (done == 4'h0 && n < 20) begin tick; n++; end
        tests++;
        if (done !== 4'b0010) begin
            fails++;
            $display("FAIL zero_done got %h want %h", done, 4'b0010);
        end
        req = 4'b0001;
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick;
            if (cmd_valid !== 1'b0 || done !== 4'h0 || grant !== 4'h0) bad = 1'b1;
        end
        tests++;
        if (bad !== 1'b0) begin
            fails++;
            $display("FAIL zero_port0 got activity for LEN=0 port want none");
        end
        req = '0; cmd_ack = 1'b0; beat = 1'b0;
    endtask

    task automatic test_stall;
        logic bad;
        do_reset;
        req = 4'b0001; addr[0 +: ASIZE] = 23'h2AAAAA; len[0 +: LEN_W] = 9'd3; cmd_ack = 1'b0; beat = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick;
            if ({cmd_valid, cmd_write, cmd_addr, cmd_len, grant, dm_out} !==
                {1'b1, 1'b1, 23'h2AAAAA, 9'd3, 4'b0001, 4'hF}) bad = 1'b1;
            beat = 1'b1;
            cmd_ack = (i == 4);
        end
        tests++;
        if (bad !== 1'b0) begin
            fails++;
            $display("FAIL stall_issue got unstable command want stable");
        end
        for (int j = 0; j < 3; j++) begin
            tick;
            tests++;
            if ({cmd_valid, dm_out, done} !== {1'b0, 4'h0, 4'h0}) begin
                fails++;
                $display("FAIL stall_xfer %0d got %h want %h", j, {cmd_valid, dm_out, done}, {1'b0, 4'h0, 4'h0});
            end
            beat = 1'b1; cmd_ack = 1'b0;
        end
        tick;
        tests++;
        if (done !== 4'b0001) begin
            fails++;
            $display("FAIL stall_done got %h want %h", done, 4'b0001);
        end
        beat = 1'b0; req = '0;
        tick;
    endtask

    task automatic test_reset_mid;
        int n;
        req = 4'b0010; len[LEN_W +: LEN_W] = 9'd8; addr[ASIZE +: ASIZE] = 23'h0ABCDE; cmd_ack = 1'b1; beat = 1'b0;
        tick;
        tick;
        beat = 1'b1;
        tick;
        tick;
        beat = 1'b0; cmd_ack = 1'b0; req = '0; rst_n = 1'b0;
        #1;
        tests++;
        if ({cmd_valid, cmd_write, cmd_addr, cmd_len, grant, done, dm_out, wr_sel} !==
            {1'b0, 1'b0, 23'h0, 9'h0, 4'h0, 4'h0, 4'hF, 1'b0}) begin
            fails++;
            $display("FAIL reset_mid got %h want %h",
                {cmd_valid, cmd_write, cmd_addr, cmd_len, grant, done, dm_out, wr_sel},
                {1'b0, 1'b0, 23'h0, 9'h0, 4'h0, 4'h0, 4'hF, 1'b0});
        end
        tick;
        rst_n = 1'b1;
        tick; tick;
        tests++;
        if ({done, grant} !== {4'h0, 4'h0}) begin
            fails++;
            $display("FAIL reset_no_done got %h want %h", {done, grant}, {4'h0, 4'h0});
        end
        req = 4'b1001; len[0 +: LEN_W] = 9'd1; len[3*LEN_W +: LEN_W] = 9'd1; cmd_ack = 1'b1; beat = 1'b1;
        tick;
        tests++;
        if ({cmd_valid, grant} !== {1'b1, 4'b0001}) begin
            fails++;
            $display("FAIL reset_ptr got %h want %h", {cmd_valid, grant}, {1'b1, 4'b0001});
        end
        n = 0;
        while (done == 4'h0 && n < 20) begin tick; n++; end
        req = 4'b1000;
        n = 0;
        tick;
        while (!cmd_valid && n < 20) begin tick; n++; end
        tests++;
        if ({cmd_valid, grant, cmd_write} !== {1'b1, 4'b1000, 1'b0}) begin
            fails++;
            $display("FAIL port3_grant got %h want %h", {cmd_valid, grant, cmd_write}, {1'b1, 4'b1000, 1'b0});
        end
        n = 0;
        while (done == 4'h0 && n < 20) begin tick; n++; end
        tests++;
        if (done !== 4'b1000) begin
            fails++;
            $display("FAIL port3_done got %h want %h", done, 4'b1000);
        end
        req = '0; cmd_ack = 1'b0; beat = 1'b0;
        tick;
    endtask

    initial begin
        test_reset;
        test_single_write;
        test_fairness;
        test_refresh;
        test_zero_len;
        test_stall;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
